mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter (instruction fetch + data) in front of a single memory
// controller. One transaction is outstanding at a time. The data port normally
// wins; an optional starvation counter lets a waiting fetch in periodically.
//
// Build option:
//   MEM_ARB_FAIR_EN  defined   -> a 4-bit counter tracks consecutive data
//                                 grants while a fetch waits; once it reaches
//                                 STARVE_MAX the fetch wins the next arbitration.
//                    undefined -> strict data priority, no counter.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global stall, holds all state)
//   flush                          pipeline flush, cancels in-flight reads
//   i_req/i_addr -> i_done/i_data  instruction fetch port
//   d_req/d_wr/d_len/d_addr/d_value -> d_done/d_data  data port
//   m_waiting/m_wr/m_len/m_addr/m_value  request held towards memory
//   m_ready/m_res                  completion pulse and read data from memory
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no request outstanding; arbitrates when no flush / no done
// BUSY_I    | fetch outstanding; result goes to i_data with i_done
// BUSY_D    | data access outstanding; result goes to d_data with d_done
// DRAIN     | flushed read still outstanding; wait for m_ready, drop result
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush,

   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_done,
   output logic [31:0] i_data,

   input  logic        d_req,
   input  logic        d_wr,
   input  logic [2:0]  d_len,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_value,
   output logic        d_done,
   output logic [31:0] d_data,

   output logic        m_waiting,
   output logic        m_wr,
   output logic [2:0]  m_len,
   output logic [31:0] m_addr,
   output logic [31:0] m_value,
   input  logic        m_ready,
   input  logic [31:0] m_res
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY_I = 2'd1;
   localparam logic [1:0] ST_BUSY_D = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   localparam logic [2:0] LEN_WORD  = 3'b010;

   // The starvation counter is 4 bits wide, so the threshold must fit.
   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("mem_arbiter: STARVE_MAX must be in 1..15");
   end

   logic [1:0]  r_state;
   logic        r_m_waiting;
   logic        r_m_wr;
   logic [2:0]  r_m_len;
   logic [31:0] r_m_addr;
   logic [31:0] r_m_value;
   logic        r_i_done;
   logic        r_d_done;
   logic [31:0] r_i_data;
   logic [31:0] r_d_data;

   logic        w_arb_ok;
   logic        w_starved;
   logic        w_grant_i;
   logic        w_grant_d;
   logic        w_cancel;

   // No grant while a done pulse is out: this gives the mandatory idle
   // turnaround cycle and keeps a port from being re-granted on its own done.
   assign w_arb_ok = (r_state == ST_IDLE) && !flush && !r_i_done && !r_d_done;

`ifdef MEM_ARB_FAIR_EN
   logic [3:0] r_starve_cnt;

   assign w_starved = i_req && (r_starve_cnt == 4'(STARVE_MAX));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_starve_cnt <= 4'd0;
      end else if (rdy_in) begin
         if (w_grant_i) begin
            r_starve_cnt <= 4'd0;
         end else if (w_grant_d) begin
            if (!i_req) begin
               r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != 4'hF) begin
               r_starve_cnt <= r_starve_cnt + 4'd1;
            end
         end
      end
   end
`else
   assign w_starved = 1'b0;
`endif

   assign w_grant_i = w_arb_ok && i_req && (w_starved || !d_req);
   assign w_grant_d = w_arb_ok && d_req && !w_grant_i;

   // Stores are never cancelled: memory has already been told to write.
   assign w_cancel  = flush &&
                      ((r_state == ST_BUSY_I) ||
                       ((r_state == ST_BUSY_D) && !r_m_wr));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state     <= ST_IDLE;
         r_m_waiting <= 1'b0;
         r_m_wr      <= 1'b0;
         r_m_len     <= 3'd0;
         r_m_addr    <= 32'd0;
         r_m_value   <= 32'd0;
         r_i_done    <= 1'b0;
         r_d_done    <= 1'b0;
         r_i_data    <= 32'd0;
         r_d_data    <= 32'd0;
      end else if (rdy_in) begin
         r_i_done <= 1'b0;
         r_d_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_i) begin
                  r_state     <= ST_BUSY_I;
                  r_m_waiting <= 1'b1;
                  r_m_wr      <= 1'b0;
                  r_m_len     <= LEN_WORD;
                  r_m_addr    <= i_addr;
                  r_m_value   <= 32'd0;
               end else if (w_grant_d) begin
                  r_state     <= ST_BUSY_D;
                  r_m_waiting <= 1'b1;
                  r_m_wr      <= d_wr;
                  r_m_len     <= d_len;
                  r_m_addr    <= d_addr;
                  r_m_value   <= d_value;
               end
            end
            ST_BUSY_I, ST_BUSY_D: begin
               if (w_cancel) begin
                  // A flush landing on the completion edge drops the result
                  // directly; otherwise wait out the read in DRAIN.
                  if (m_ready) begin
                     r_state     <= ST_IDLE;
                     r_m_waiting <= 1'b0;
                  end else begin
                     r_state     <= ST_DRAIN;
                  end
               end else if (m_ready) begin
                  r_state     <= ST_IDLE;
                  r_m_waiting <= 1'b0;
                  if (r_state == ST_BUSY_I) begin
                     r_i_data <= m_res;
                     r_i_done <= 1'b1;
                  end else begin
                     r_d_data <= m_res;
                     r_d_done <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (m_ready) begin
                  r_state     <= ST_IDLE;
                  r_m_waiting <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_m_waiting <= 1'b0;
            end
         endcase
      end
   end

   assign m_waiting = r_m_waiting;
   assign m_wr      = r_m_wr;
   assign m_len     = r_m_len;
   assign m_addr    = r_m_addr;
   assign m_value   = r_m_value;
   assign i_done    = r_i_done;
   assign i_data    = r_i_data;
   assign d_done    = r_d_done;
   assign d_data    = r_d_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Randomized requesters and memory drive mem_arbiter; a transaction-level
// reference model (one outstanding job, a "void" flag for flushed reads,
// a done pulse, and a data-grant streak) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int STARVE = 4;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        flush;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_done;
   logic [31:0] i_data;
   logic        d_req;
   logic        d_wr;
   logic [2:0]  d_len;
   logic [31:0] d_addr;
   logic [31:0] d_value;
   logic        d_done;
   logic [31:0] d_data;
   logic        m_waiting;
   logic        m_wr;
   logic [2:0]  m_len;
   logic [31:0] m_addr;
   logic [31:0] m_value;
   logic        m_ready;
   logic [31:0] m_res;

   mem_arbiter #(.STARVE_MAX(STARVE)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .flush     (flush),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_done    (i_done),
      .i_data    (i_data),
      .d_req     (d_req),
      .d_wr      (d_wr),
      .d_len     (d_len),
      .d_addr    (d_addr),
      .d_value   (d_value),
      .d_done    (d_done),
      .d_data    (d_data),
      .m_waiting (m_waiting),
      .m_wr      (m_wr),
      .m_len     (m_len),
      .m_addr    (m_addr),
      .m_value   (m_value),
      .m_ready   (m_ready),
      .m_res     (m_res)
   );

   always #5 clk_in = ~clk_in;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit        md_busy;
   bit        md_is_d;
   bit        md_void;
   bit        mo_wr;
   bit [2:0]  mo_len;
   bit [31:0] mo_addr;
   bit [31:0] mo_value;
   bit        mo_idone;
   bit        mo_ddone;
   bit [31:0] mo_idata;
   bit [31:0] mo_ddata;
   int        n_igrant;
   int        n_dgrant;
`ifdef MEM_ARB_FAIR_EN
   int        streak;
`endif

   function automatic void model_reset();
      md_busy  = 0;
      md_is_d  = 0;
      md_void  = 0;
      mo_wr    = 0;
      mo_len   = 3'd0;
      mo_addr  = 32'd0;
      mo_value = 32'd0;
      mo_idone = 0;
      mo_ddone = 0;
      mo_idata = 32'd0;
      mo_ddata = 32'd0;
`ifdef MEM_ARB_FAIR_EN
      streak   = 0;
`endif
   endfunction

   function automatic void model_step();
      bit prev_done;
      bit take_i;
      if (!rdy_in) return;
      prev_done = mo_idone || mo_ddone;
      mo_idone  = 0;
      mo_ddone  = 0;
      if (!md_busy) begin
         if (!flush && !prev_done) begin
`ifdef MEM_ARB_FAIR_EN
            take_i = i_req && (!d_req || streak == STARVE);
`else
            take_i = i_req && !d_req;
`endif
            if (take_i) begin
               md_busy = 1; md_is_d = 0; md_void = 0;
               mo_wr = 0; mo_len = 3'd2; mo_addr = i_addr; mo_value = 32'd0;
               n_igrant++;
`ifdef MEM_ARB_FAIR_EN
               streak = 0;
`endif
            end else if (d_req) begin
               md_busy = 1; md_is_d = 1; md_void = 0;
               mo_wr = d_wr; mo_len = d_len; mo_addr = d_addr; mo_value = d_value;
               n_dgrant++;
`ifdef MEM_ARB_FAIR_EN
               streak = i_req ? streak + 1 : 0;
`endif
            end
         end
      end else begin
         if (flush && !(md_is_d && mo_wr)) md_void = 1;
         if (m_ready) begin
            md_busy = 0;
            if (!md_void) begin
               if (md_is_d) begin mo_ddata = m_res; mo_ddone = 1; end
               else         begin mo_idata = m_res; mo_idone = 1; end
            end
         end
      end
   endfunction

   task automatic check_outputs(input string pfx);
      chk({pfx, "m_waiting"}, 32'(m_waiting), 32'(md_busy));
      chk({pfx, "m_wr"},      32'(m_wr),      32'(mo_wr));
      chk({pfx, "m_len"},     32'(m_len),     32'(mo_len));
      chk({pfx, "m_addr"},    m_addr,         mo_addr);
      chk({pfx, "m_value"},   m_value,        mo_value);
      chk({pfx, "i_done"},    32'(i_done),    32'(mo_idone));
      chk({pfx, "d_done"},    32'(d_done),    32'(mo_ddone));
      chk({pfx, "i_data"},    i_data,         mo_idata);
      chk({pfx, "d_data"},    d_data,         mo_ddata);
   endtask

   // ---------------- requesters / memory ----------------
   bit i_pend;
   bit d_pend;

   // mode 0: fully random traffic; mode 1: both ports always requesting,
   // no flush, no stall (exercises priority / fairness).
   task automatic run_cycle(input int mode);
      @(negedge clk_in);
      check_outputs("");
      if (mo_idone) i_pend = 0;
      if (mo_ddone) d_pend = 0;
      flush = (mode == 0) && ($urandom_range(0, 11) == 0);
      if (flush) begin
         i_pend = 0;
         d_pend = 0;
      end
      if (!flush && !i_pend && (mode == 1 || $urandom_range(0, 2) == 0)) begin
         i_pend = 1;
         i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!flush && !d_pend && (mode == 1 || $urandom_range(0, 2) == 0)) begin
         d_pend  = 1;
         d_wr    = 1'($urandom);
         d_len   = 3'($urandom);
         d_addr  = $urandom;
         d_value = $urandom;
      end
      i_req   = i_pend;
      d_req   = d_pend;
      m_ready = (mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      m_res   = $urandom;
      rdy_in  = (mode == 1) ? 1'b1 : ($urandom_range(0, 9) != 0);
      @(posedge clk_in);
      model_step();
   endtask

   task automatic clear_inputs();
      i_pend = 0; d_pend = 0;
      flush = 0; i_req = 0; d_req = 0; d_wr = 0; d_len = 3'd0;
      i_addr = 32'd0; d_addr = 32'd0; d_value = 32'd0;
      m_ready = 0; m_res = 32'd0; rdy_in = 1;
   endtask

   initial begin
      int budget;
      int ig0;
      int dg0;
      n_igrant = 0;
      n_dgrant = 0;
      clear_inputs();
      model_reset();
      rst_in = 1'b1;
      #12;
      check_outputs("rst_");
      @(negedge clk_in);
      rst_in = 1'b0;

      for (int k = 0; k < 3000; k++) run_cycle(0);

      // Saturated traffic: strict data priority or periodic fetch wins.
      ig0 = n_igrant;
      dg0 = n_dgrant;
      for (int k = 0; k < 600; k++) run_cycle(1);
`ifdef MEM_ARB_FAIR_EN
      chk("fair_igrants_seen", 32'(n_igrant - ig0 > 0), 32'd1);
`else
      chk("strict_igrants_seen", 32'(n_igrant - ig0 > 1), 32'd0);
`endif
      chk("sat_dgrants_seen", 32'(n_dgrant - dg0 > 10), 32'd1);

      // Asynchronous reset in the middle of a fetch.
      budget = 0;
      while (!(md_busy && !md_is_d) && budget < 500) begin
         run_cycle(0);
         budget++;
      end
      chk("fetch_busy_reached", 32'(md_busy && !md_is_d), 32'd1);
      @(negedge clk_in);
      check_outputs("pre_rst_");
      #2 rst_in = 1'b1;
      #1;
      chk("arst_m_waiting", 32'(m_waiting), 32'd0);
      chk("arst_m_len",     32'(m_len),     32'd0);
      chk("arst_m_addr",    m_addr,         32'd0);
      model_reset();
      check_outputs("arst_");
      clear_inputs();
      @(negedge clk_in);
      rst_in = 1'b0;

      for (int k = 0; k < 1500; k++) run_cycle(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
